// File: rtl/matmul2x2_stream_ctrl.sv
// Stream controller for the 2x2 matrix multiplier: loads 8 operand bytes, pulses
// the multiplier start, captures the four results and streams them out in order.
module matmul2x2_stream_ctrl #(
    parameter int DW = 8,
    parameter int RW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] mul_a00,
    output logic [DW-1:0] mul_a01,
    output logic [DW-1:0] mul_a10,
    output logic [DW-1:0] mul_a11,
    output logic [DW-1:0] mul_b00,
    output logic [DW-1:0] mul_b01,
    output logic [DW-1:0] mul_b10,
    output logic [DW-1:0] mul_b11,
    output logic          mul_start,
    input  logic [RW-1:0] mul_c00,
    input  logic [RW-1:0] mul_c01,
    input  logic [RW-1:0] mul_c10,
    input  logic [RW-1:0] mul_c11,
    input  logic          mul_done,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [RW-1:0] m_data,
    output logic          m_last,
    output logic          busy
);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_e;

    state_e        state_q;
    logic [2:0]    idx_q;
    logic [1:0]    ridx_q;
    logic [DW-1:0] op_q  [8];
    logic [RW-1:0] res_q [4];
    logic          mul_start_q;
    logic          m_valid_q;
    logic [RW-1:0] m_data_q;
    logic          m_last_q;

    // NOTE: every register here, including the operand and result arrays, is plain
    // flops with a defined reset value; updates use <= so all reads see pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            ridx_q      <= '0;
            mul_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            for (int i = 0; i < 8; i++) op_q[i] <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            mul_start_q <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (s_valid) begin
                        op_q[idx_q] <= s_data;
                        idx_q       <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q     <= START;
                            mul_start_q <= 1'b1;
                        end
                    end
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (mul_done) begin
                        res_q[0]  <= mul_c00;
                        res_q[1]  <= mul_c01;
                        res_q[2]  <= mul_c10;
                        res_q[3]  <= mul_c11;
                        m_valid_q <= 1'b1;
                        m_data_q  <= mul_c00;
                        m_last_q  <= 1'b0;
                        ridx_q    <= '0;
                        state_q   <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (m_ready) begin
                        if (ridx_q == 2'd3) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            ridx_q    <= '0;
                            state_q   <= LOAD;
                        end else begin
                            // Preload the next word so m_data is already registered.
                            ridx_q   <= ridx_q + 2'd1;
                            m_data_q <= res_q[ridx_q + 2'd1];
                            m_last_q <= (ridx_q == 2'd2);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign mul_start = mul_start_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign mul_a00   = op_q[0];
    assign mul_a01   = op_q[1];
    assign mul_a10   = op_q[2];
    assign mul_a11   = op_q[3];
    assign mul_b00   = op_q[4];
    assign mul_b01   = op_q[5];
    assign mul_b10   = op_q[6];
    assign mul_b11   = op_q[7];

endmodule

// File: tb/tb_matmul2x2_stream_ctrl.sv
// Self-checking bench: golden multiplier, expected-result scoreboard built from the
// stimulus matrices, and directed tests for latency, stalls, resets and back-to-back loads.
module tb_matmul2x2_stream_ctrl;

    localparam int DW = 8;
    localparam int RW = 17;

    typedef logic [DW-1:0] mat_t [8];
    typedef logic [RW-1:0] res_t [4];
    typedef struct {
        logic [RW-1:0] d;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic [DW-1:0] mul_a00, mul_a01, mul_a10, mul_a11;
    logic [DW-1:0] mul_b00, mul_b01, mul_b10, mul_b11;
    logic          mul_start;
    logic [RW-1:0] mul_c00, mul_c01, mul_c10, mul_c11;
    logic          mul_done;
    logic          m_valid, m_ready, m_last, busy;
    logic [RW-1:0] m_data;

    always #5 clk = ~clk;

    matmul2x2_stream_ctrl #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mul_a00(mul_a00), .mul_a01(mul_a01), .mul_a10(mul_a10), .mul_a11(mul_a11),
        .mul_b00(mul_b00), .mul_b01(mul_b01), .mul_b10(mul_b10), .mul_b11(mul_b11),
        .mul_start(mul_start),
        .mul_c00(mul_c00), .mul_c01(mul_c01), .mul_c10(mul_c10), .mul_c11(mul_c11),
        .mul_done(mul_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // C = A x B with A,B given row-major as a00,a01,a10,a11,b00,b01,b10,b11.
    function automatic res_t matmul(input mat_t m);
        res_t r;
        r[0] = RW'(int'(m[0]) * int'(m[4]) + int'(m[1]) * int'(m[6]));
        r[1] = RW'(int'(m[0]) * int'(m[5]) + int'(m[1]) * int'(m[7]));
        r[2] = RW'(int'(m[2]) * int'(m[4]) + int'(m[3]) * int'(m[6]));
        r[3] = RW'(int'(m[2]) * int'(m[5]) + int'(m[3]) * int'(m[7]));
        return r;
    endfunction

    mat_t dut_ops;
    assign dut_ops[0] = mul_a00;
    assign dut_ops[1] = mul_a01;
    assign dut_ops[2] = mul_a10;
    assign dut_ops[3] = mul_a11;
    assign dut_ops[4] = mul_b00;
    assign dut_ops[5] = mul_b01;
    assign dut_ops[6] = mul_b10;
    assign dut_ops[7] = mul_b11;

    // Golden multiplier: samples start, raises done one edge later plus done_delay edges.
    logic          model_done = 1'b0;
    logic          spur_done = 1'b0;
    logic [RW-1:0] model_c [4] = '{default: '0};
    int            done_delay = 0;

    assign mul_done = model_done | spur_done;
    assign mul_c00  = spur_done ? RW'(999) : model_c[0];
    assign mul_c01  = spur_done ? RW'(999) : model_c[1];
    assign mul_c10  = spur_done ? RW'(999) : model_c[2];
    assign mul_c11  = spur_done ? RW'(999) : model_c[3];

    initial begin
        mat_t mm;
        res_t rr;
        forever begin
            @(negedge clk);
            if (rst_n && mul_start) begin
                mm = dut_ops;
                rr = matmul(mm);
                @(posedge clk);
                repeat (done_delay) @(posedge clk);
                #1;
                model_c    = rr;
                model_done = 1'b1;
                @(posedge clk);
                #1;
                model_done = 1'b0;
                model_c    = '{default: '0};
            end
        end
    end

    // Downstream ready: 0 = ready until ready_limit words accepted, 1 = random.
    int ready_mode  = 0;
    int ready_limit = 1000000;
    int popped      = 0;

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) m_ready = 1'($urandom_range(0, 1));
            else                 m_ready = (popped < ready_limit);
        end
    end

    // Scoreboard and per-cycle invariants, sampled on the falling edge.
    word_t         exp_q [$];
    mat_t          cur_mat = '{default: '0};
    logic          prev_start = 1'b0;
    logic          prev_hold = 1'b0;
    logic [RW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            starts = 0;
    int            last_hs_cyc = -10;
    int            first_hs_cyc = 0;

    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                check("s_ready_is_not_busy", s_ready, !busy);
                if (mul_start) begin
                    starts++;
                    check("start_single_cycle", prev_start, 0);
                end
                prev_start = mul_start;
                if (busy)
                    for (int i = 0; i < 8; i++) check("operand_hold", dut_ops[i], cur_mat[i]);
                if (prev_hold) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, prev_data);
                    check("stall_last", m_last, prev_last);
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
                prev_last = m_last;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("m_data", m_data, w.d);
                        check("m_last", m_last, w.last);
                    end
                    popped++;
                    if (m_last) last_hs_cyc = cyc + 1;
                end
            end
        end
    end

    // Sends the first n bytes of m; a full matrix also queues its expected results.
    task automatic send_bytes(input mat_t m, input int n, input bit gaps);
        res_t r;
        int   t;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = m[i];
            t = 0;
            while (!s_ready && t < 300) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!s_ready) begin
                check("s_ready_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i == 0) first_hs_cyc = cyc;
        end
        s_valid = 1'b0;
        if (n == 8) begin
            cur_mat = m;
            r = matmul(m);
            for (int k = 0; k < 4; k++) exp_q.push_back('{d: r[k], last: (k == 3)});
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_idle", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a00"}, mul_a00, 0);
        check({tag, "_mul_b11"}, mul_b11, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t m1, mff, m2;
        res_t r;
        int   t;
        m1  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        mff = '{default: 8'd255};
        m2  = '{8'd2, 8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        s_valid = 1'b0;
        s_data  = '0;

        // Pin the model against hand-computed products.
        r = matmul(m1);
        check("model_c00", r[0], 19);
        check("model_c01", r[1], 22);
        check("model_c10", r[2], 43);
        check("model_c11", r[3], 50);
        r = matmul(mff);
        check("model_full", r[3], 130050);
        r = matmul(m2);
        check("model_m2_c00", r[0], 8);
        check("model_m2_c11", r[3], 26);

        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: back-to-back load, exact latency to start and first result.
        starts = 0;
        send_bytes(m1, 8, 0);
        check("t1_start_now", mul_start, 1);
        check("t1_busy", busy, 1);
        @(posedge clk); #1;
        check("t1_start_gone", mul_start, 0);
        check("t1_no_valid_yet", m_valid, 0);
        @(posedge clk); #1;
        check("t1_valid", m_valid, 1);
        check("t1_first_word", m_data, 19);
        check("t1_first_not_last", m_last, 0);
        drain();
        check("t1_one_start", starts, 1);

        // 2: full-width operands.
        send_bytes(mff, 8, 0);
        drain();

        // 3: input gaps and downstream stalls.
        ready_mode = 1;
        send_bytes(m1, 8, 1);
        drain();
        ready_mode = 0;

        // 4: spurious done in LOAD, then a slow multiplier.
        @(posedge clk); #1 spur_done = 1'b1;
        @(posedge clk); #1 spur_done = 1'b0;
        check("t4_spur_valid", m_valid, 0);
        check("t4_spur_busy", busy, 0);
        done_delay = 5;
        starts = 0;
        send_bytes(m2, 8, 0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check("t4_wait_valid", m_valid, 0);
            check("t4_wait_busy", busy, 1);
            check("t4_wait_start", mul_start, 0);
        end
        drain();
        check("t4_one_start", starts, 1);
        done_delay = 0;

        // 5a: reset after five input bytes.
        send_bytes(m1, 5, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_load_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        send_bytes(m1, 8, 0);
        drain();

        // 5b: reset after two output words.
        ready_limit = popped + 2;
        send_bytes(m1, 8, 0);
        t = 0;
        while (popped < ready_limit && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("t5_two_words", popped, ready_limit);
        @(posedge clk); #1;
        check("t5_stalled_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_unload_rst");
        exp_q.delete();
        ready_limit = 1000000;
        @(posedge clk); #1 rst_n = 1'b1;
        send_bytes(m1, 8, 0);
        drain();

        // 6: two matrices back to back.
        starts = 0;
        send_bytes(m1, 8, 0);
        send_bytes(m2, 8, 0);
        check("t6_next_load_cycle", first_hs_cyc, last_hs_cyc + 1);
        drain();
        check("t6_two_starts", starts, 2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
